// File: rtl/uart_rx.sv
// UART receiver with a 2-flop synchronized line, 2-of-3 majority voting per bit and optional parity.
// Result strobes are registered one cycle after the stop bit resolves.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] RX_P_DATA,
    output logic                  RX_D_VLD,
    output logic                  Par_err,
    output logic                  Stp_err,
    output logic                  Busy
);
    // state  | meaning
    // IDLE   | line idle, waiting for a synchronized low
    // START  | validating the start bit
    // DATA   | shifting in payload bits, LSB first
    // PARITY | checking the parity bit
    // STOP   | checking the stop bit and queueing the frame result
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state;
    logic [1:0]            sync;
    logic                  line;
    logic [5:0]            p_norm;
    logic [5:0]            p_lat;
    logic [5:0]            half;
    logic [5:0]            cnt;
    logic [2:0]            samp;
    logic                  bit_val;
    logic                  bit_done;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  par_bad;
    logic                  pend_vld;
    logic                  pend_par;
    logic                  pend_stp;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], RX_IN};
    end

    assign line = sync[1];

    always_comb begin
        p_norm = 6'd8;
        if (PRESCALE == 6'd8 || PRESCALE == 6'd16 || PRESCALE == 6'd32)
            p_norm = PRESCALE;
    end

    assign half     = {1'b0, p_lat[5:1]};
    assign bit_done = (cnt == p_lat - 6'd1);
    assign bit_val  = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign Busy     = (state != IDLE);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            samp      <= 3'b000;
            bit_idx   <= '0;
            shift     <= '0;
            p_lat     <= 6'd8;
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            par_bad   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_par  <= 1'b0;
            pend_stp  <= 1'b0;
        end else begin
            pend_vld <= 1'b0;
            pend_par <= 1'b0;
            pend_stp <= 1'b0;
            if (state != IDLE) begin
                cnt <= bit_done ? 6'd0 : cnt + 6'd1;
                if (cnt == half - 6'd1) samp[0] <= line;
                if (cnt == half)        samp[1] <= line;
                if (cnt == half + 6'd1) samp[2] <= line;
            end
            case (state)
                IDLE: begin
                    cnt <= 6'd0;
                    if (!line) begin
                        state     <= START;
                        p_lat     <= p_norm;
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                        par_bad   <= 1'b0;
                    end
                end
                START: if (bit_done) begin
                    bit_idx <= '0;
                    state   <= bit_val ? IDLE : DATA;
                end
                DATA: if (bit_done) begin
                    shift   <= (shift >> 1) | (DATA_WIDTH'(bit_val) << (DATA_WIDTH - 1));
                    bit_idx <= bit_idx + BW'(1);
                    if (bit_idx == LAST_BIT)
                        state <= par_en_l ? PARITY : STOP;
                end
                PARITY: if (bit_done) begin
                    par_bad <= (bit_val != ((^shift) ^ par_typ_l));
                    state   <= STOP;
                end
                STOP: if (bit_done) begin
                    // parity failure masks a bad stop bit
                    pend_par <= par_bad;
                    pend_stp <= !par_bad && !bit_val;
                    pend_vld <= !par_bad && bit_val;
                    par_bad  <= 1'b0;
                    state    <= line ? IDLE : START;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // shift is stable here: the next frame cannot reach DATA within one cycle
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            RX_P_DATA <= '0;
            RX_D_VLD  <= 1'b0;
            Par_err   <= 1'b0;
            Stp_err   <= 1'b0;
        end else begin
            RX_D_VLD <= pend_vld;
            Par_err  <= pend_par;
            Stp_err  <= pend_stp;
            if (pend_vld) RX_P_DATA <= shift;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, hand sequences for glitch, back-to-back
// and mid-frame reset, then random frames checked against a frame-level reference model.
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       Par_err;
    logic       Stp_err;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam int K_VLD = 1;
    localparam int K_PAR = 2;
    localparam int K_STP = 3;
    localparam int K_MULTI = 9;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        int         psc;
        bit         pen;
        bit         ptyp;
        logic [7:0] d;
        bit         flip;
        bit         stop;
        int         kind;
        logic [7:0] xdata;
    } vec_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .rst(rst), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .Par_err(Par_err),
        .Stp_err(Stp_err), .Busy(Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        ev_t e;
        int  n;
        n = int'(RX_D_VLD) + int'(Par_err) + int'(Stp_err);
        if (n != 0) begin
            e.kind = (n > 1) ? K_MULTI : RX_D_VLD ? K_VLD : Par_err ? K_PAR : K_STP;
            e.data = RX_P_DATA;
            e.cyc  = cyc;
            obs_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int eff_p(input int psc);
        return (psc == 8 || psc == 16 || psc == 32) ? psc : 8;
    endfunction

    // parity bit a correct transmitter sends, optionally inverted
    function automatic bit tx_parity(input logic [7:0] d, input bit ptyp, input bit flip);
        return bit'(($countones(d) + int'(ptyp) + int'(flip)) % 2);
    endfunction

    function automatic int model_kind(input logic [7:0] d, input bit pen, input bit ptyp,
                                      input bit pbit, input bit stop);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (pen && ((ones % 2) != (ptyp ? 1 : 0))) return K_PAR;
        if (!stop) return K_STP;
        return K_VLD;
    endfunction

    task automatic send_frame(input int psc, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit pbit, input bit stop, input bit scramble, input bit glitch,
                              output int start_cyc);
        int          p;
        int          nb;
        logic [10:0] bits;
        p        = eff_p(psc);
        PRESCALE = 6'(psc);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        bits     = pen ? {stop, pbit, d, 1'b0} : {1'b0, stop, d, 1'b0};
        nb       = pen ? 11 : 10;
        start_cyc = cyc;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < p; c++) begin
                RX_IN = (glitch && i >= 1 && i <= 8 && c == p / 2 + 1) ? ~bits[i] : bits[i];
                if (i == 0 && c == 4 && scramble) begin
                    PRESCALE = 6'($urandom_range(0, 63));
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
                if (i == 2 && c == p / 2) chk("busy_mid_frame", Busy, 1);
                @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
            chk({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
        end
        chk({tag, "_idle"}, Busy, 0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] xdata, input int start_cyc,
                             input bit pen, input int psc);
        ev_t e;
        e.kind = kind;
        e.data = xdata;
        e.cyc  = start_cyc + 4 + (pen ? 11 : 10) * eff_p(psc);
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input int psc, input bit pen, input bit ptyp, input logic [7:0] d,
                             input bit pbit, input bit stop, input bit scramble, input bit glitch,
                             input int kind, input logic [7:0] xdata, input string tag);
        int s;
        send_frame(psc, pen, ptyp, d, pbit, stop, scramble, glitch, s);
        expect_ev(kind, xdata, s, pen, psc);
        if (kind == K_VLD) last_good = d;
        repeat (12) @(negedge CLK);
        check_events(tag);
    endtask

    initial begin
        vec_t       tbl[8];
        int         s1;
        int         s2;
        int         busy_cnt;
        int         psc;
        bit         pen;
        bit         ptyp;
        bit         flip;
        bit         stop;
        bit         glitch;
        bit         pbit;
        int         kind;
        logic [7:0] d;
        logic [7:0] frame55;

        tbl[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, K_VLD, 8'hA5};
        tbl[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, K_VLD, 8'h3C};
        tbl[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, K_PAR, 8'h3C};
        tbl[3] = '{32, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, K_STP, 8'h3C};
        tbl[4] = '{16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, K_PAR, 8'h3C};
        tbl[5] = '{12, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, K_VLD, 8'h5A};
        tbl[6] = '{8,  1'b1, 1'b1, 8'h00, 1'b0, 1'b1, K_VLD, 8'h00};
        tbl[7] = '{32, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, K_VLD, 8'hC3};

        repeat (3) @(negedge CLK);
        chk("reset_data", RX_P_DATA, 8'h00);
        chk("reset_vld", RX_D_VLD, 0);
        chk("reset_par_err", Par_err, 0);
        chk("reset_stp_err", Stp_err, 0);
        chk("reset_busy", Busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            pbit = tx_parity(tbl[i].d, tbl[i].ptyp, tbl[i].flip);
            run_frame(tbl[i].psc, tbl[i].pen, tbl[i].ptyp, tbl[i].d, pbit, tbl[i].stop, 1'b1,
                      1'b0, tbl[i].kind, tbl[i].xdata, $sformatf("vec%0d", i));
        end

        // start-bit glitch: three low cycles must be rejected after one bit time
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN    = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            busy_cnt += int'(Busy);
            @(negedge CLK);
        end
        chk("glitch_busy_cycles", busy_cnt, 16);
        check_events("glitch");

        // back-to-back frames with no idle gap
        send_frame(8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, s1);
        send_frame(8, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, s2);
        expect_ev(K_VLD, 8'h01, s1, 1'b0, 8);
        expect_ev(K_VLD, 8'h80, s2, 1'b0, 8);
        last_good = 8'h80;
        repeat (12) @(negedge CLK);
        chk("b2b_spacing", (obs_q.size() == 2) ? obs_q[1].cyc - obs_q[0].cyc : -1, 80);
        check_events("b2b");

        // reset in the middle of the data bits of 0x55
        frame55  = 8'h55;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = frame55[i];
            repeat (8) @(negedge CLK);
        end
        rst = 1'b1;
        #1;
        chk("midreset_busy", Busy, 0);
        chk("midreset_data", RX_P_DATA, 8'h00);
        RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (10) @(negedge CLK);
        run_frame(8, 1'b0, 1'b0, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, K_VLD, 8'h66, "after_reset");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: psc = 8;
                3, 4, 5: psc = 16;
                6, 7:    psc = 32;
                8:       psc = int'($urandom_range(0, 63));
                default: psc = 24;
            endcase
            pen    = 1'($urandom);
            ptyp   = 1'($urandom);
            d      = 8'($urandom);
            flip   = ($urandom_range(0, 4) == 0);
            stop   = ($urandom_range(0, 5) != 0);
            glitch = ($urandom_range(0, 2) == 0);
            pbit   = tx_parity(d, ptyp, flip);
            kind   = model_kind(d, pen, ptyp, pbit, stop);
            run_frame(psc, pen, ptyp, d, pbit, stop, 1'b1, glitch, kind,
                      (kind == K_VLD) ? d : last_good, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame; equals the RX frame width consumed by the system controller.
REQ-002 CLK  input  1  oversampling clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 RX_IN  input  1  serial line, idle high, asynchronous to CLK.
REQ-005 PRESCALE  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = parity bit present.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd.
REQ-008 RX_P_DATA  output  DATA_WIDTH  last good payload, held until the next good frame.
REQ-009 RX_D_VLD  output  1  one-cycle strobe per good frame.
REQ-010 Par_err  output  1  one-cycle strobe on parity mismatch.
REQ-011 Stp_err  output  1  one-cycle strobe on bad stop bit.
REQ-012 Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 RX_IN SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 PRESCALE, PAR_EN and PAR_TYP SHALL be latched on leaving IDLE; changes mid-frame SHALL have no effect.
REQ-016 Latched PRESCALE values other than 8, 16 or 32 SHALL be treated as 8.
REQ-017 Bit-time edge counter SHALL count 0..P-1 (P = latched prescale) and wrap to 0 at each bit boundary.
REQ-018 Each bit SHALL be the 2-of-3 majority of samples taken at edge counts P/2-1, P/2, P/2+1; the bit is resolved at edge count P-1.
REQ-019 IDLE -> START when the synchronized line is 0; the edge counter starts at 0 in the next cycle.
REQ-020 START: a resolved 1 (glitch) SHALL return the FSM to IDLE with no strobe; a resolved 0 SHALL go to DATA.
REQ-021 DATA: DATA_WIDTH bits SHALL be received LSB first; after the last bit go to PARITY if PAR_EN, else STOP.
REQ-022 PARITY: expected bit = XOR of payload for even, XNOR for odd; the comparison result SHALL be held for STOP.
REQ-023 STOP: on resolution, exactly one of the following SHALL occur in the next cycle:
  - parity mismatch -> Par_err=1
  - else stop bit 0 -> Stp_err=1
  - else RX_D_VLD=1 and RX_P_DATA updated in the same cycle.
REQ-024 When both parity and stop are bad, only Par_err SHALL strobe.
REQ-025 Errored frames SHALL leave RX_P_DATA unchanged.
REQ-026 After STOP, the FSM SHALL go to START directly if the synchronized line is already 0, else to IDLE, so back-to-back frames with no idle gap are received.
REQ-027 RX_D_VLD SHALL rise exactly 3 + N*P cycles after the first CLK edge that samples RX_IN low, where N = 10 without parity and 11 with parity.
REQ-028 All strobes SHALL be registered, glitch-free and exactly one cycle wide.

Reset
REQ-029 On rst=1, asynchronously: FSM=IDLE, counters=0, synchronizer=1, RX_P_DATA=0, RX_D_VLD=0, Par_err=0, Stp_err=0, Busy=0.
REQ-030 Reset mid-frame SHALL abort the frame with no strobe.
REQ-031 After release, the FSM SHALL wait in IDLE and only accept a new start edge from the synchronized line.

Verification
REQ-032 P=8, no parity, frame 0xA5 -> RX_D_VLD strobes once at 3+80 cycles, RX_P_DATA=0xA5, no error strobe.
REQ-033 P=16, PAR_EN=1, PAR_TYP=0, 0x3C sent with parity 0 -> RX_D_VLD, RX_P_DATA=0x3C; resend with parity 1 -> Par_err only, RX_P_DATA stays 0x3C.
REQ-034 P=32, odd parity, 0xFF with stop bit forced 0 -> Stp_err only, no RX_D_VLD.
REQ-035 RX_IN low for 3 cycles then high (P=16) -> FSM returns to IDLE; Busy clears after one bit time; no strobes.
REQ-036 Two back-to-back frames 0x01 then 0x80 with zero idle gap (P=8) -> two RX_D_VLD strobes exactly 80 cycles apart.
REQ-037 rst pulsed during DATA of frame 0x55, then 0x66 sent -> no strobe for 0x55; RX_D_VLD with RX_P_DATA=0x66.
